// File: rtl/ysyx_22041207_trap_unit.sv
// Machine-mode trap sequencer: takes ecall/mret/timer-interrupt at commit,
// emits one-cycle CSR update strobes, then holds a PC redirect to fetch.
module ysyx_22041207_trap_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        ecall_req,
  input  logic        mret_req,
  input  logic        irq_timer,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  input  logic        redirect_ready,
  output logic        panic,
  output logic        wMepc,
  output logic [63:0] mepc_v,
  output logic        wMcause,
  output logic [63:0] mcause_v,
  output logic        pc_mret,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        stall,
  output logic        busy
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned MIE_BIT = 3;
  localparam logic [XLEN-1:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
  localparam logic [XLEN-1:0] CAUSE_ECALL = 64'd11;
  localparam logic [1:0]      MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SAVE  = 2'd1,
    S_MRET  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_is_irq;
  logic              r_panic;
  logic              r_wmepc;
  logic              r_wmcause;
  logic              r_pc_mret;
  logic              r_redir_valid;
  logic              r_busy;
  logic [XLEN-1:0]   r_mepc_v;
  logic [XLEN-1:0]   r_mcause_v;
  logic [XLEN-1:0]   r_redir_pc;

  logic              w_irq_take;
  logic              w_accept;
  logic              w_is_irq_nxt;
  logic [XLEN-1:0]   w_cause_nxt;
  logic [XLEN-1:0]   w_epc_nxt;
  logic [XLEN-1:0]   w_redir_pc_nxt;
  logic [XLEN-1:0]   w_mtvec_base;
  logic [XLEN-1:0]   w_vec_off;
  logic [XLEN-1:0]   w_trap_target;
  logic              w_unused;

  // Request qualification: only an enabled timer interrupt counts; accept only from IDLE.
  assign w_irq_take = irq_timer & mstatus_i[MIE_BIT];
  assign w_accept   = (r_state == S_IDLE) & commit_valid & (w_irq_take | ecall_req | mret_req);

  // Handler address: vectored mode offsets interrupts by 4*cause code, exceptions use base.
  assign w_mtvec_base  = {mtvec_i[XLEN-1:2], 2'b00};
  assign w_vec_off     = {r_mcause_v[XLEN-3:0], 2'b00};
  assign w_trap_target = ((mtvec_i[1:0] == MODE_VECTORED) && r_is_irq)
                       ? XLEN'(w_mtvec_base + w_vec_off)
                       : w_mtvec_base;

  assign w_unused = &{1'b0, mstatus_i[XLEN-1:MIE_BIT+1], mstatus_i[MIE_BIT-1:0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, trap payload capture and redirect target selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_is_irq_nxt   = r_is_irq;
    w_cause_nxt    = '0;
    w_epc_nxt      = '0;
    w_redir_pc_nxt = r_redir_pc;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_irq_take) begin
            w_state_nxt  = S_SAVE;
            w_is_irq_nxt = 1'b1;
            w_cause_nxt  = CAUSE_TIMER;
            w_epc_nxt    = commit_pc;
          end else if (ecall_req) begin
            w_state_nxt  = S_SAVE;
            w_is_irq_nxt = 1'b0;
            w_cause_nxt  = CAUSE_ECALL;
            w_epc_nxt    = commit_pc;
          end else begin
            w_state_nxt  = S_MRET;
            w_is_irq_nxt = 1'b0;
          end
        end
      end
      S_SAVE: begin
        w_state_nxt    = S_REDIR;
        w_redir_pc_nxt = w_trap_target;
      end
      S_MRET: begin
        w_state_nxt    = S_REDIR;
        w_redir_pc_nxt = mepc_i;
      end
      S_REDIR: begin
        if (redirect_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state; mepc/mcause carry the latched payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_irq      <= 1'b0;
      r_panic       <= 1'b0;
      r_wmepc       <= 1'b0;
      r_wmcause     <= 1'b0;
      r_pc_mret     <= 1'b0;
      r_redir_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_mepc_v      <= '0;
      r_mcause_v    <= '0;
      r_redir_pc    <= '0;
    end else begin
      r_is_irq      <= w_is_irq_nxt;
      r_panic       <= (w_state_nxt == S_SAVE);
      r_wmepc       <= (w_state_nxt == S_SAVE);
      r_wmcause     <= (w_state_nxt == S_SAVE);
      r_pc_mret     <= (w_state_nxt == S_MRET);
      r_redir_valid <= (w_state_nxt == S_REDIR);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_mepc_v      <= w_epc_nxt;
      r_mcause_v    <= w_cause_nxt;
      r_redir_pc    <= w_redir_pc_nxt;
    end
  end

  assign panic          = r_panic;
  assign wMepc          = r_wmepc;
  assign wMcause        = r_wmcause;
  assign pc_mret        = r_pc_mret;
  assign redirect_valid = r_redir_valid;
  assign busy           = r_busy;
  assign mepc_v         = r_mepc_v;
  assign mcause_v       = r_mcause_v;
  assign redirect_pc    = r_redir_pc;

  // Stall covers the accept cycle itself; forced low while reset is held.
  assign stall = ~rst & (w_accept | (r_state != S_IDLE));

endmodule

// File: tb/tb_ysyx_22041207_trap_unit.sv
// Bench for the trap sequencer: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_ysyx_22041207_trap_unit;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        ecall_req;
  logic        mret_req;
  logic        irq_timer;
  logic [63:0] mstatus_i;
  logic [63:0] mtvec_i;
  logic [63:0] mepc_i;
  logic        redirect_ready;
  logic        panic;
  logic        wMepc;
  logic [63:0] mepc_v;
  logic        wMcause;
  logic [63:0] mcause_v;
  logic        pc_mret;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        busy;

  int total;
  int bad;

  ysyx_22041207_trap_unit dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .ecall_req(ecall_req), .mret_req(mret_req), .irq_timer(irq_timer),
    .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .redirect_ready(redirect_ready), .panic(panic), .wMepc(wMepc), .mepc_v(mepc_v),
    .wMcause(wMcause), .mcause_v(mcause_v), .pc_mret(pc_mret),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One trap in flight at a time: remembered by kind, payload and age in cycles.
  bit          m_active;
  int          m_age;
  int          m_kind;      // 0 = mret, 1 = ecall, 2 = interrupt
  logic [63:0] m_epc;
  logic [63:0] m_cause;
  logic [63:0] m_target;
  logic [6:0]  e_flags;     // {panic,wMepc,wMcause,pc_mret,redirect_valid,stall,busy}
  logic [63:0] e_mepc;
  logic [63:0] e_mcause;
  bit          m_irq_ok;
  bit          m_acc;

  initial begin
    m_active = 1'b0;
    m_age    = 0;
    m_kind   = 0;
    m_target = '0;
  end

  // Compare process: every falling edge, predict outputs from the inputs and the model.
  always @(negedge clk) begin
    e_flags  = '0;
    e_mepc   = '0;
    e_mcause = '0;
    if (rst) begin
      m_active = 1'b0;
      chk("reset_redirect_pc", redirect_pc, 64'h0);
    end else if (!m_active) begin
      m_irq_ok = irq_timer && mstatus_i[3];
      m_acc    = commit_valid && (m_irq_ok || ecall_req || mret_req);
      e_flags[1] = m_acc;
      if (m_acc) begin
        m_active = 1'b1;
        m_age    = 1;
        m_epc    = commit_pc;
        if (m_irq_ok) begin
          m_kind  = 2;
          m_cause = 64'h8000_0000_0000_0007;
        end else if (ecall_req) begin
          m_kind  = 1;
          m_cause = 64'd11;
        end else begin
          m_kind  = 0;
        end
      end
    end else if (m_age == 1) begin
      e_flags[1:0] = 2'b11;
      if (m_kind != 0) begin
        e_flags[6:4] = 3'b111;
        e_mepc       = m_epc;
        e_mcause     = m_cause;
        m_target     = mtvec_i - 64'(mtvec_i[1:0]);
        if (mtvec_i[1:0] == 2'd1 && m_kind == 2)
          m_target = m_target + 64'd4 * (m_cause & 64'h7FFF_FFFF_FFFF_FFFF);
      end else begin
        e_flags[3] = 1'b1;
        m_target   = mepc_i;
      end
      m_age = 2;
    end else begin
      e_flags[2:0] = 3'b111;
      chk("redirect_pc", redirect_pc, m_target);
      if (redirect_ready) m_active = 1'b0;
    end
    chk("flags", 64'({panic, wMepc, wMcause, pc_mret, redirect_valid, stall, busy}), 64'(e_flags));
    chk("mepc_v", mepc_v, e_mepc);
    chk("mcause_v", mcause_v, e_mcause);
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    commit_valid   = 1'b0;
    ecall_req      = 1'b0;
    mret_req       = 1'b0;
    redirect_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    quiet();
    irq_timer = 1'b0;
    commit_pc = '0;
    mstatus_i = '0;
    mtvec_i   = '0;
    mepc_i    = '0;
    sample();
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    step();
    rst = 1'b0;

    // Ecall, direct mode.
    step();
    mtvec_i = 64'h8000_0100; commit_pc = 64'h8000_0040;
    commit_valid = 1'b1; ecall_req = 1'b1;
    sample();
    chk("ecall_T_stall", 64'(stall), 64'h1);
    step(); quiet();
    sample();
    chk("ecall_T1_strobes", 64'({panic, wMepc, wMcause, pc_mret}), 64'hE);
    chk("ecall_T1_mepc", mepc_v, 64'h8000_0040);
    chk("ecall_T1_mcause", mcause_v, 64'd11);
    step(); redirect_ready = 1'b1;
    sample();
    chk("ecall_T2_valid", 64'(redirect_valid), 64'h1);
    chk("ecall_T2_pc", redirect_pc, 64'h8000_0100);
    step(); quiet();
    sample();
    chk("ecall_done_stall", 64'(stall), 64'h0);

    // Timer interrupt with ecall present, vectored mode.
    step();
    mtvec_i = 64'h8000_0101; mstatus_i = 64'h8; irq_timer = 1'b1;
    commit_pc = 64'h8000_2000; commit_valid = 1'b1; ecall_req = 1'b1;
    sample();
    step(); quiet();
    sample();
    chk("irq_mcause", mcause_v, 64'h8000_0000_0000_0007);
    chk("irq_mepc", mepc_v, 64'h8000_2000);
    step(); redirect_ready = 1'b1; irq_timer = 1'b0;
    sample();
    chk("irq_target", redirect_pc, 64'h8000_011C);
    step(); quiet();

    // Mret with back-pressure; a new ecall during REDIR must be ignored.
    step();
    mepc_i = 64'h8000_0044; commit_valid = 1'b1; mret_req = 1'b1;
    sample();
    step(); quiet();
    sample();
    chk("mret_strobes", 64'({panic, wMepc, wMcause, pc_mret}), 64'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      commit_valid = 1'b1; ecall_req = 1'b1; commit_pc = 64'h8000_0090;
      sample();
      chk("bp_hold", 64'({redirect_valid, stall, panic}), 64'h6);
      chk("bp_pc", redirect_pc, 64'h8000_0044);
    end
    step(); quiet(); redirect_ready = 1'b1;
    sample();
    step(); quiet();
    sample();
    chk("bp_release_busy", 64'(busy), 64'h0);

    // Masked interrupt on an ordinary commit.
    step();
    mstatus_i = 64'h0; irq_timer = 1'b1; commit_valid = 1'b1;
    sample();
    chk("masked_stall", 64'(stall), 64'h0);
    step(); quiet(); irq_timer = 1'b0;
    sample();
    chk("masked_busy", 64'(busy), 64'h0);

    // Reset during SAVE, then a clean ecall.
    step();
    commit_valid = 1'b1; ecall_req = 1'b1; commit_pc = 64'h8000_0300;
    sample();
    step(); quiet(); rst = 1'b1;
    sample();
    chk("rst_mid_out", 64'({panic, wMepc, wMcause, pc_mret, redirect_valid, stall, busy}), 64'h0);
    chk("rst_mid_mepc", mepc_v, 64'h0);
    step(); rst = 1'b0;
    step();
    commit_valid = 1'b1; ecall_req = 1'b1; commit_pc = 64'h8000_0400;
    sample();
    step(); quiet();
    sample();
    chk("post_rst_panic", 64'(panic), 64'h1);
    chk("post_rst_mepc", mepc_v, 64'h8000_0400);
    step(); redirect_ready = 1'b1;
    step(); quiet();

    // Random traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst            = ($urandom_range(0, 199) == 0);
      commit_valid   = $urandom_range(0, 1);
      ecall_req      = ($urandom_range(0, 3) == 0);
      mret_req       = ($urandom_range(0, 3) == 0);
      irq_timer      = ($urandom_range(0, 3) == 0);
      mstatus_i      = {$urandom, $urandom};
      mtvec_i        = {$urandom, $urandom};
      mepc_i         = {$urandom, $urandom};
      commit_pc      = {$urandom, $urandom};
      redirect_ready = ($urandom_range(0, 4) < 2);
    end
    step(); quiet(); rst = 1'b0;
    sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_trap_unit.md
# ysyx_22041207_trap_unit

Trap sequencer that initiates machine-mode traps and returns toward the CSR file. It takes ecall/mret/timer-interrupt events from the commit stage and produces the one-cycle CSR update strobes (`panic`, `wMepc`/`mepc_v`, `wMcause`/`mcause_v`, `pc_mret`). It reads back `mtvec`/`mepc`/`mstatus` and issues a held PC redirect to fetch, stalling the pipeline from acceptance until fetch takes the redirect.

## Interface
- No parameters; all data paths are XLEN = 64.
- `clk`  in  1  system clock, all state on posedge
- `rst`  in  1  asynchronous, active-high reset
- `commit_valid`  in  1  an instruction is at commit this cycle
- `commit_pc`  in  64  PC of the committing instruction
- `ecall_req`  in  1  committing instruction is ecall
- `mret_req`  in  1  committing instruction is mret
- `irq_timer`  in  1  level timer-interrupt pending (MTIP)
- `mstatus_i`  in  64  current mstatus (bit 3 = MIE)
- `mtvec_i`  in  64  current mtvec (bits 1:0 = mode)
- `mepc_i`  in  64  current mepc
- `redirect_ready`  in  1  fetch accepts redirect this cycle
- `panic`  out  1  trap entry strobe to CSR file (MIE→MPIE, MIE←0)
- `wMepc`  out  1  mepc write strobe
- `mepc_v`  out  64  mepc write value
- `wMcause`  out  1  mcause write strobe
- `mcause_v`  out  64  mcause write value
- `pc_mret`  out  1  mret strobe to CSR file (MPIE→MIE, MPIE←1)
- `redirect_valid`  out  1  redirect target valid
- `redirect_pc`  out  64  redirect target
- `stall`  out  1  freeze commit/front end
- `busy`  out  1  FSM not in IDLE

## Operation
- States: IDLE, SAVE, MRET, REDIR.
- Accept (IDLE only, `commit_valid`=1), priority:
  1. Interrupt: `irq_timer` & `mstatus_i[3]`. Cause = 0x8000_0000_0000_0007; epc = `commit_pc`. The committing instruction is not executed, even if it is ecall/mret. Go to SAVE.
  2. Ecall: cause = 11 (0xB); epc = `commit_pc`. Go to SAVE.
  3. Mret: go to MRET.
- On accept, latch cause, epc and an `is_irq` flag.
- Requests with `commit_valid`=0, or while not in IDLE, are ignored.
- SAVE: for one cycle, `panic`=`wMepc`=`wMcause`=1, `mepc_v`=latched epc, `mcause_v`=latched cause. Next state is REDIR, with `redirect_pc` loaded as follows:
  - mode 0 (direct), or mode 1 (vectored) with an exception: {`mtvec_i`[63:2],2'b00}.
  - mode 1 with an interrupt: {`mtvec_i`[63:2],2'b00} + 4×cause[62:0] (cause 7 gives base+0x1C). Addition wraps mod 2^64.
  - modes 2/3: treated as direct.
- MRET: for one cycle, `pc_mret`=1. Next state is REDIR with `redirect_pc` ← `mepc_i`.
- REDIR: `redirect_valid`=1, `redirect_pc` stays stable. Return to IDLE on the cycle `redirect_ready`=1.
- `stall` = accept condition (combinational) OR state≠IDLE. `busy` = state≠IDLE.
- Strobes are registered state decodes and are mutually exclusive. `mepc_v`/`mcause_v` read 0 outside SAVE.

## Timing
- Reset: state IDLE. All outputs are 0: `panic`, `wMepc`, `wMcause`, `pc_mret`, `redirect_valid`, `stall`, `busy`, `mepc_v`, `mcause_v`, `redirect_pc`.
- Accept at posedge of cycle T:
  - T: `stall`=1.
  - T+1: strobes active (SAVE or MRET). The CSR file updates at the end of T+1.
  - T+2: `redirect_valid`=1.
  - Earliest return to IDLE is the end of T+2, so minimum trap latency is 3 cycles with `stall` high throughout.
- The redirect handshake completes on a cycle where both `redirect_valid` and `redirect_ready` are 1. `redirect_ready` while not in REDIR has no effect.
- The mtvec/mepc sample happens at the SAVE/MRET cycle. A CSR write to mtvec in that same cycle is not seen.
- Simultaneous `ecall_req` & `mret_req`: ecall wins.
- `irq_timer` while MIE=0: ignored.
- `irq_timer` rising during SAVE/MRET/REDIR: ignored until IDLE. It is taken at the next commit if still pending and MIE is set.
- `rst` mid-sequence: immediate return to IDLE with all outputs 0. No partial strobe completes after `rst` asserts.

## Test plan
- Ecall, direct mode: `mtvec_i`=0x8000_0100, ecall at `commit_pc`=0x8000_0040 → T+1 `panic`/`wMepc`/`wMcause`=1, `mepc_v`=0x8000_0040, `mcause_v`=11. T+2 `redirect_pc`=0x8000_0100 with `redirect_ready`=1, then `stall` drops.
- Timer interrupt, vectored mode: `mtvec_i`=0x8000_0101, MIE=1, `irq_timer`=1, `ecall_req`=1, `commit_pc`=0x8000_2000 → `mcause_v`=0x8000_0000_0000_0007, `mepc_v`=0x8000_2000, `redirect_pc`=0x8000_011C, ecall not taken.
- Mret: `mepc_i`=0x8000_0044 → T+1 `pc_mret`=1 (one cycle, no other strobes). T+2 `redirect_pc`=0x8000_0044.
- Back-pressure: hold `redirect_ready`=0 for 5 cycles in REDIR → `redirect_valid`, `redirect_pc` and `stall` all held. A new ecall presented meanwhile is ignored, and no second strobe occurs.
- Masked interrupt: MIE=0, `irq_timer`=1, ordinary commit → no activity, `stall`=0.
- Reset mid-op: assert `rst` during SAVE → same cycle all outputs 0 and state IDLE. After release, an ecall is accepted normally.
